// File: rtl/branch_resolve_unit.sv
// Resolution side of the branch predictor: holds in-flight predictions in order,
// checks each one against the EX outcome, and issues flush/redirect plus training updates.
module branch_resolve_unit #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             pred_valid,
  input  logic             pred_taken,
  input  logic [31:0]      pred_tgt,
  input  logic [31:0]      pred_fall,
  input  logic             res_valid,
  input  logic             res_taken,
  output logic             flush,
  output logic [31:0]      redirect_pc,
  output logic             upd_valid,
  output logic             upd_taken,
  output logic             upd_mispred,
  output logic             q_empty,
  output logic             q_full,
  output logic             err,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;

  logic          ent_taken [DEPTH];
  logic [31:0]   ent_tgt   [DEPTH];
  logic [31:0]   ent_fall  [DEPTH];

  logic push_req;
  logic pop;
  logic mis;
  logic accept;
  logic overflow;
  logic empty_res;

  assign q_empty = (count == '0);
  assign q_full  = (count == FULL_CNT);

  // Fetch during the flush cycle is wrong-path, so it never enters the queue.
  assign push_req  = pred_valid & ~stall & ~flush;
  assign pop       = res_valid & ~stall & ~q_empty;
  assign mis       = pop & (res_taken != ent_taken[rd_ptr]);
  assign accept    = push_req & ~mis & (~q_full | pop);
  assign overflow  = push_req & q_full & ~pop;
  assign empty_res = res_valid & ~stall & q_empty;

  always_ff @(posedge clk) begin
    if (accept) begin
      ent_taken[wr_ptr] <= pred_taken;
      ent_tgt[wr_ptr]   <= pred_tgt;
      ent_fall[wr_ptr]  <= pred_fall;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      flush       <= 1'b0;
      redirect_pc <= '0;
      upd_valid   <= 1'b0;
      upd_taken   <= 1'b0;
      upd_mispred <= 1'b0;
      err         <= 1'b0;
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      flush     <= mis;
      upd_valid <= pop;

      if (overflow || empty_res)
        err <= 1'b1;

      if (pop) begin
        upd_taken   <= res_taken;
        upd_mispred <= mis;
        redirect_pc <= res_taken ? ent_tgt[rd_ptr] : ent_fall[rd_ptr];
        if (branch_cnt != '1)
          branch_cnt <= branch_cnt + 1'b1;
        if (mis && mispred_cnt != '1)
          mispred_cnt <= mispred_cnt + 1'b1;
      end

      // A mispredict discards every younger entry: the queue collapses onto wr_ptr.
      if (mis) begin
        rd_ptr <= wr_ptr;
        count  <= '0;
      end else begin
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        if (accept)
          wr_ptr <= wr_ptr + 1'b1;
        if (accept && !pop)
          count <= count + 1'b1;
        else if (!accept && pop)
          count <= count - 1'b1;
      end
    end
  end

endmodule
